spectrum_peak_detect: RTL
=========================

Name: spectrum_peak_detect

Overview:
Downstream of the rectangular-to-polar stage in the postprocess chain. Consumes the per-bin (magnitude, phase) stream produced for each FFT frame. Over each frame it locates the largest-magnitude bin inside a configurable search window and accumulates the window's total magnitude. Once per frame it emits the bin index, magnitude and phase of the peak, the magnitude sum, and a threshold-detect flag.

Parameters:
N_BINS, 256, bins per FFT frame; power of two, >= 4.
DW, 32, magnitude/phase width; signed Q16.16, same format as the polar stage outputs.
IDX_W, $clog2(N_BINS), bin index width.
SKIP_BINS, 1, bins with index < SKIP_BINS are never eligible (DC rejection); 0 disables.
SEARCH_HI, N_BINS/2-1, highest eligible bin index; SKIP_BINS <= SEARCH_HI < N_BINS.

Ports:
clk  in  1  clock.
arstn  in  1  asynchronous active-low reset.
i_vld  in  1  input sample valid; no backpressure, gaps allowed.
i_sof  in  1  start-of-frame; qualified by i_vld.
i_mag  in  DW  signed bin magnitude.
i_phase  in  DW  signed bin phase.
i_thresh  in  DW  signed detection threshold; sampled on the frame's last bin.
o_vld  out  1  one-cycle pulse: frame result valid.
o_idx  out  IDX_W  peak bin index.
o_mag  out  DW  peak magnitude.
o_phase  out  DW  phase of peak bin.
o_sum  out  DW+IDX_W  sum of eligible-bin magnitudes (signed, no overflow possible).
o_det  out  1  o_mag > i_thresh (signed, strict).

Behaviour:
- Reset (arstn=0, async): bin counter=0, best-valid=0, accumulator=0. All outputs are 0, including o_vld.
- Bin counter cnt (IDX_W bits) advances only on i_vld. It wraps N_BINS-1 -> 0.
- i_vld=1 & i_sof=1: the current sample is treated as bin 0 regardless of cnt. Any partial frame in progress is discarded with no o_vld. best-valid and the accumulator are cleared before this sample is processed.
- Eligible sample: i_vld=1 and SKIP_BINS <= bin <= SEARCH_HI. Ineligible samples advance cnt only.
- For each eligible sample:
  - accumulator += sign-extended i_mag.
  - If best-valid=0, or i_mag > best_mag (signed, strict), load best_mag/best_phase/best_idx and set best-valid.
  - Ties keep the lowest index.
- Frame end: accepted sample with bin == N_BINS-1.
  - The candidate for that cycle is computed combinationally: best state updated with the current sample if it is eligible, accumulator likewise.
  - Outputs o_idx/o_mag/o_phase/o_sum/o_det are registered on that edge.
  - o_vld=1 on the following cycle for exactly one cycle. Latency is 1 cycle from the last-bin input to o_vld.
  - On the same edge, best-valid and the accumulator are cleared and cnt wraps to 0. The next sample may arrive on the very next cycle with no dead time.
- Result outputs hold their values until the next o_vld. o_vld is a single-cycle pulse.
- If no bin was eligible (unreachable with legal parameters), o_idx/o_mag/o_phase=0 and o_det=0.
- Negative magnitudes are compared as signed; no saturation.
- Reset mid-frame: the partial frame is lost and the first post-reset sample is bin 0.

Test Plan:
- N_BINS=8, SKIP_BINS=1, SEARCH_HI=3, thresh=0x40000; mags bins0..7 = 0x100000,0x10000,0x50000,0x30000,0x90000,0,0,0, phase=bin*0x1000 -> one o_vld pulse 1 cycle after bin7; o_idx=2, o_mag=0x50000, o_phase=0x2000, o_sum=0x90000, o_det=1.
- Same config, bins1 and 3 = 0x20000, bin2 = 0x10000, thresh=0x20000 -> o_idx=1, o_mag=0x20000, o_sum=0x50000, o_det=0 (strict compare).
- Frame fed with random 0..3-cycle i_vld gaps, followed back-to-back by a second frame with peak at bin3 -> results identical to the gap-free run; second o_vld shows o_idx=3 exactly 8 accepted samples later.
- i_sof asserted on the 5th sample of a frame, then 7 more samples -> no o_vld for the aborted frame; one o_vld after the 8th sample counted from the sof sample.
- arstn pulsed low after 4 samples -> all outputs read 0 immediately (asynchronously); next full 8-sample frame produces a correct result.
- Last bin eligible (SEARCH_HI=7, largest mag 0x70000 at bin7) -> o_idx=7, o_mag=0x70000, confirming the same-cycle final-bin bypass.

Source files
------------

// File: rtl/spectrum_peak_detect_if.sv
// spectrum_peak_detect_if: per-bin (mag, phase) input stream and per-frame peak result bundle.
interface spectrum_peak_detect_if #(
    parameter int DW    = 32,
    parameter int IDX_W = 8
) ();
    logic                i_vld;
    logic                i_sof;
    logic [DW-1:0]       i_mag;
    logic [DW-1:0]       i_phase;
    logic [DW-1:0]       i_thresh;
    logic                o_vld;
    logic [IDX_W-1:0]    o_idx;
    logic [DW-1:0]       o_mag;
    logic [DW-1:0]       o_phase;
    logic [DW+IDX_W-1:0] o_sum;
    logic                o_det;
    modport master (
        output i_vld, i_sof, i_mag, i_phase, i_thresh,
        input  o_vld, o_idx, o_mag, o_phase, o_sum, o_det
    );
    modport slave (
        input  i_vld, i_sof, i_mag, i_phase, i_thresh,
        output o_vld, o_idx, o_mag, o_phase, o_sum, o_det
    );
endinterface

// File: rtl/spectrum_peak_detect.sv
// spectrum_peak_detect: per-frame peak bin search and magnitude sum over a bin window.
module spectrum_peak_detect #(
    parameter int N_BINS    = 256,
    parameter int DW        = 32,
    parameter int IDX_W     = $clog2(N_BINS),
    parameter int SKIP_BINS = 1,
    parameter int SEARCH_HI = N_BINS/2-1
) (
    input  logic                   clk,
    input  logic                   arstn,
    spectrum_peak_detect_if.slave  s
);
    localparam int SW = DW + IDX_W;
    function automatic logic [N_BINS-1:0] elig_mask();
        logic [N_BINS-1:0] m;
        for (int i = 0; i < N_BINS; i++) m[i] = (i >= SKIP_BINS) && (i <= SEARCH_HI);
        return m;
    endfunction
    localparam logic [N_BINS-1:0] ELIG = elig_mask();
    logic [IDX_W-1:0] r_cnt, r_best_idx, r_o_idx;
    logic             r_bv, r_o_vld, r_o_det;
    logic [SW-1:0]    r_sum, r_o_sum;
    logic [DW-1:0]    r_best_mag, r_best_phase, r_o_mag, r_o_phase;
    logic             w_sof, w_elig, w_bv, w_take, w_bv_n, w_last;
    logic [IDX_W-1:0] w_bin, w_idx;
    logic [SW-1:0]    w_sum;
    logic [DW-1:0]    w_mag, w_phase;
    // A start-of-frame sample sees a cleared frame state, so the bypass covers sof too
    assign w_sof   = s.i_vld && s.i_sof;
    assign w_bin   = w_sof ? '0 : r_cnt;
    assign w_bv    = w_sof ? 1'b0 : r_bv;
    assign w_elig  = s.i_vld && ELIG[w_bin];
    assign w_take  = w_elig && (!w_bv || $signed(s.i_mag) > $signed(r_best_mag));
    assign w_bv_n  = w_bv || w_elig;
    assign w_mag   = w_take ? s.i_mag : r_best_mag;
    assign w_phase = w_take ? s.i_phase : r_best_phase;
    assign w_idx   = w_take ? w_bin : r_best_idx;
    assign w_sum   = (w_sof ? '0 : r_sum) + (w_elig ? {{IDX_W{s.i_mag[DW-1]}}, s.i_mag} : '0);
    assign w_last  = s.i_vld && (w_bin == IDX_W'(N_BINS-1));
    always_ff @(posedge clk or negedge arstn)
        if (!arstn) begin
            r_cnt        <= '0;
            r_bv         <= 1'b0;
            r_sum        <= '0;
            r_best_mag   <= '0;
            r_best_phase <= '0;
            r_best_idx   <= '0;
            r_o_vld      <= 1'b0;
            r_o_idx      <= '0;
            r_o_mag      <= '0;
            r_o_phase    <= '0;
            r_o_sum      <= '0;
            r_o_det      <= 1'b0;
        end else begin
            r_o_vld      <= w_last;
            if (s.i_vld) r_cnt <= w_bin + 1'b1;
            r_bv         <= w_bv_n && !w_last;
            r_sum        <= w_last ? '0 : w_sum;
            r_best_mag   <= w_mag;
            r_best_phase <= w_phase;
            r_best_idx   <= w_idx;
            if (w_last) begin
                r_o_idx   <= w_bv_n ? w_idx : '0;
                r_o_mag   <= w_bv_n ? w_mag : '0;
                r_o_phase <= w_bv_n ? w_phase : '0;
                r_o_sum   <= w_sum;
                r_o_det   <= w_bv_n && ($signed(w_mag) > $signed(s.i_thresh));
            end
        end
    assign s.o_vld   = r_o_vld;
    assign s.o_idx   = r_o_idx;
    assign s.o_mag   = r_o_mag;
    assign s.o_phase = r_o_phase;
    assign s.o_sum   = r_o_sum;
    assign s.o_det   = r_o_det;
endmodule
